// File: rtl/dreg_pkg.sv
// Shared types and helpers for the serial data-register frame receiver.
// Holds the default word width, the receiver state encoding and a clog2 helper.
package dreg_pkg;

    localparam int SIZE_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_PAR     = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dreg_frame_hold.sv
// Single-entry valid/ready holding register for completed frames.
// A delivery that finds the slot full and not draining is dropped and raises a sticky overrun.
module dreg_frame_hold #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         deliver,
    input  logic [W-1:0] din,
    input  logic         ready,
    input  logic         clr,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         overrun
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         overrun_q, overrun_d;
    logic         pop;
    logic         accept;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        pop       = valid_q & ready;
        accept    = deliver & (~valid_q | ready);
        valid_d   = valid_q;
        data_d    = data_q;
        overrun_d = overrun_q;

        if (accept) begin
            valid_d = 1'b1;
            data_d  = din;
        end else if (pop) begin
            valid_d = 1'b0;
        end

        // A fresh overrun outranks a clear arriving in the same cycle.
        if (deliver && !accept) begin
            overrun_d = 1'b1;
        end else if (clr) begin
            overrun_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid   = valid_q;
    assign dout    = data_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/dreg_frame_rx.sv
// Frame receiver that counts shift strobes of the upstream data register and hands out full words.
// Define DREG_FRAME_RX_PARITY_EN to expect a trailing even-parity bit after each frame.
module dreg_frame_rx
    import dreg_pkg::*;
#(
    parameter int SIZE = SIZE_DEFAULT
) (
    input  logic            dreg_frame_rx_cport_clk,
    input  logic            dreg_frame_rx_cport_rst,
    input  logic            dreg_frame_rx_cport_en,
    input  logic            dreg_frame_rx_cport_sp,
    input  logic            dreg_frame_rx_iport_si,
    input  logic [SIZE-1:0] dreg_frame_rx_ipport_pi,
    input  logic            dreg_frame_rx_cport_clr,
    input  logic            dreg_frame_rx_cport_ready,
    output logic            dreg_frame_rx_oport_valid,
    output logic [SIZE-1:0] dreg_frame_rx_oport_word,
    output logic            dreg_frame_rx_oport_perr,
    output logic            dreg_frame_rx_oport_overrun
);

    localparam int               CNT_W    = clog2(SIZE + 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SIZE);
    localparam state_e           ST_FIRST = (SIZE == 1) ? ST_CAPTURE : ST_SHIFT;

    logic clk;
    logic rst;
    logic strobe;
    logic abort;

    assign clk    = dreg_frame_rx_cport_clk;
    assign rst    = dreg_frame_rx_cport_rst;
    assign strobe = dreg_frame_rx_cport_en & ~dreg_frame_rx_cport_sp;
    assign abort  = dreg_frame_rx_cport_en &  dreg_frame_rx_cport_sp;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             deliver;
    logic [SIZE:0]    deliver_data;
    logic [SIZE:0]    hold_data;

    assign cnt_inc = bit_cnt_q + CNT_ONE;

`ifdef DREG_FRAME_RX_PARITY_EN
    logic [SIZE-1:0] staging_q, staging_d;
`else
    logic unused_si;
    assign unused_si = dreg_frame_rx_iport_si;
`endif

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        deliver      = 1'b0;
        deliver_data = '0;
`ifdef DREG_FRAME_RX_PARITY_EN
        staging_d    = staging_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    bit_cnt_d = CNT_ONE;
                    state_d   = ST_FIRST;
                end
            end
            ST_SHIFT: begin
                if (strobe) begin
                    bit_cnt_d = cnt_inc;
                    if (cnt_inc == CNT_FULL) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                bit_cnt_d = '0;
`ifdef DREG_FRAME_RX_PARITY_EN
                // The parity bit must arrive after this cycle, so a strobe here is ignored.
                staging_d = dreg_frame_rx_ipport_pi;
                state_d   = ST_PAR;
`else
                deliver      = 1'b1;
                deliver_data = {1'b0, dreg_frame_rx_ipport_pi};
                if (strobe) begin
                    bit_cnt_d = CNT_ONE;
                    state_d   = ST_FIRST;
                end else begin
                    state_d   = ST_IDLE;
                end
`endif
            end
            ST_PAR: begin
`ifdef DREG_FRAME_RX_PARITY_EN
                if (strobe) begin
                    deliver      = 1'b1;
                    deliver_data = {(^staging_q) ^ dreg_frame_rx_iport_si, staging_q};
                    state_d      = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d   = ST_IDLE;
                bit_cnt_d = '0;
            end
        endcase

        // A parallel load upstream invalidates any partial frame, even mid-strobe.
        if (abort) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
`ifdef DREG_FRAME_RX_PARITY_EN
            staging_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
`ifdef DREG_FRAME_RX_PARITY_EN
            staging_q <= staging_d;
`endif
        end
    end

    dreg_frame_hold #(
        .W (SIZE + 1)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .deliver (deliver),
        .din     (deliver_data),
        .ready   (dreg_frame_rx_cport_ready),
        .clr     (dreg_frame_rx_cport_clr),
        .valid   (dreg_frame_rx_oport_valid),
        .dout    (hold_data),
        .overrun (dreg_frame_rx_oport_overrun)
    );

    assign dreg_frame_rx_oport_word = hold_data[SIZE-1:0];

`ifdef DREG_FRAME_RX_PARITY_EN
    assign dreg_frame_rx_oport_perr = hold_data[SIZE];
`else
    // The tag bit of the holding register is never written with 1 in this build.
    logic unused_tag;
    assign unused_tag               = hold_data[SIZE];
    assign dreg_frame_rx_oport_perr = 1'b0;
`endif

endmodule

// File: tb/tb_dreg_frame_rx.sv
// Randomised scoreboard bench for dreg_frame_rx: a frame-level model predicts each handed-out word.
// Set DREG_FRAME_RX_PARITY_EN to exercise the trailing parity bit.
module tb_dreg_frame_rx;

    localparam int SIZE = 16;

    typedef struct {
        logic [SIZE-1:0] w;
        logic            p;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            en = 1'b0;
    logic            sp = 1'b0;
    logic            si = 1'b0;
    logic            clr = 1'b0;
    logic            ready = 1'b0;
    logic [SIZE-1:0] pi = '0;
    logic            valid;
    logic [SIZE-1:0] word;
    logic            perr;
    logic            overrun;

    int   checks = 0;
    int   errors = 0;
    int   pop_cnt = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    // Frame-level reference: upstream shift register, strobe count and the output slot.
    logic [SIZE-1:0] up_reg = '0;
    logic [SIZE-1:0] m_stage = '0;
    int              m_bits = 0;
    bit              m_valid = 1'b0;
    bit              m_ovr = 1'b0;
`ifdef DREG_FRAME_RX_PARITY_EN
    bit              m_cap = 1'b0;
    bit              m_par = 1'b0;
`else
    bit              m_pend = 1'b0;
`endif

    always #5 clk = ~clk;

    dreg_frame_rx #(
        .SIZE (SIZE)
    ) dut (
        .dreg_frame_rx_cport_clk     (clk),
        .dreg_frame_rx_cport_rst     (rst),
        .dreg_frame_rx_cport_en      (en),
        .dreg_frame_rx_cport_sp      (sp),
        .dreg_frame_rx_iport_si      (si),
        .dreg_frame_rx_ipport_pi     (pi),
        .dreg_frame_rx_cport_clr     (clr),
        .dreg_frame_rx_cport_ready   (ready),
        .dreg_frame_rx_oport_valid   (valid),
        .dreg_frame_rx_oport_word    (word),
        .dreg_frame_rx_oport_perr    (perr),
        .dreg_frame_rx_oport_overrun (overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic e, input logic s, input logic b, input logic r, input logic c);
        logic strobe;
        logic abort;
        logic dlv;
        logic ovr_set;
        exp_t nw;
        strobe = e & ~s;
        abort  = e & s;
        nw.w   = m_stage;
        nw.p   = 1'b0;
`ifdef DREG_FRAME_RX_PARITY_EN
        dlv = m_par & strobe;
        nw.p = (^m_stage) ^ b;
`else
        dlv = m_pend;
`endif
        ovr_set = dlv & m_valid & ~r;
        if (dlv && !ovr_set) begin
            m_valid = 1'b1;
            exp_q.push_back(nw);
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        if (ovr_set) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;

        if (abort) up_reg = SIZE'($urandom);
        else if (strobe) up_reg = {up_reg[SIZE-2:0], b};

`ifdef DREG_FRAME_RX_PARITY_EN
        if (m_cap) begin
            m_cap = 1'b0;
            m_par = ~abort;
        end else if (abort) begin
            m_par  = 1'b0;
            m_bits = 0;
        end else if (strobe) begin
            if (m_par) begin
                m_par = 1'b0;
            end else begin
                m_bits++;
                if (m_bits == SIZE) begin
                    m_bits  = 0;
                    m_cap   = 1'b1;
                    m_stage = up_reg;
                end
            end
        end
`else
        m_pend = 1'b0;
        if (abort) begin
            m_bits = 0;
        end else if (strobe) begin
            m_bits++;
            if (m_bits == SIZE) begin
                m_bits  = 0;
                m_pend  = 1'b1;
                m_stage = up_reg;
            end
        end
`endif
    endtask

    // One clock: inputs applied now, sampled at the next rising edge; returns 1 time unit after it.
    task automatic step(input logic e, input logic s, input logic b);
        en = e;
        sp = s;
        si = b;
        @(posedge clk);
        model_edge(e, s, b, ready, clr);
        #1;
        pi = up_reg;
    endtask

    task automatic send_bits(input logic [SIZE-1:0] w);
        for (int i = SIZE - 1; i >= 0; i--) begin
            step(1'b1, 1'b0, w[i]);
        end
    endtask

    task automatic send_frame(input logic [SIZE-1:0] w);
        send_bits(w);
`ifdef DREG_FRAME_RX_PARITY_EN
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, ^w);
`endif
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("rst_valid", valid, 0);
        check("rst_word", word, 0);
        check("rst_perr", perr, 0);
        check("rst_overrun", overrun, 0);
        exp_q.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_bits  = 0;
`ifdef DREG_FRAME_RX_PARITY_EN
        m_cap = 1'b0;
        m_par = 1'b0;
`else
        m_pend = 1'b0;
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares slot status every cycle and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("valid", valid, m_valid);
            check("overrun", overrun, m_ovr);
            if (valid && ready) begin
                pop_cnt++;
                check("scoreboard_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word", word, e.w);
                    check("perr", perr, e.p);
                end
            end
        end
    end

    initial begin
        int p0;
        int first;
        int last;
        int nvalid;

        #1;
        pulse_reset();
        mon_en = 1'b1;

        // Basic frame with latency check.
        ready = 1'b1;
        send_bits(16'hA5C3);
        check("lat_capture_valid", valid, 0);
        step(1'b0, 1'b0, 1'b0);
`ifdef DREG_FRAME_RX_PARITY_EN
        check("lat_par_valid", valid, 0);
        step(1'b1, 1'b0, 1'b0);
`endif
        check("basic_valid", valid, 1);
        check("basic_word", word, 16'hA5C3);
        step(1'b0, 1'b0, 1'b0);
        check("basic_popped", valid, 0);

        // Backpressure: second frame dropped, first stays.
        ready = 1'b0;
        send_frame(16'h1234);
        send_frame(16'hBEEF);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("bp_word", word, 16'h1234);
        check("bp_valid", valid, 1);
        check("bp_overrun", overrun, 1);
        ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        ready = 1'b0;
        check("bp_popped", valid, 0);
        clr = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        check("bp_clr", overrun, 0);

        // Abort mid-frame, then a full frame: exactly one word.
        ready = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'($urandom));
        step(1'b1, 1'b1, 1'b0);
        send_frame(16'($urandom));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        check("abort_words", pop_cnt - p0, 1);

        // Reset mid-frame with a word held.
        ready = 1'b0;
        send_frame(16'h5A5A);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'($urandom));
        pulse_reset();
        ready = 1'b1;
        p0 = pop_cnt;
        send_frame(16'h00FF);
        step(1'b0, 1'b0, 1'b0);
        check("rst_frame_word", word, 16'h00FF);
        step(1'b0, 1'b0, 1'b0);
        check("rst_frame_count", pop_cnt - p0, 1);

        // Back-to-back frames with ready held high.
        first  = -1;
        last   = -1;
        nvalid = 0;
`ifdef DREG_FRAME_RX_PARITY_EN
        p0 = pop_cnt;
        for (int f = 0; f < 4; f++) send_frame(16'($urandom));
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("b2b_count", pop_cnt - p0, 4);
        check("b2b_overrun", overrun, 0);

        // Parity tagging.
        send_bits(16'h0001);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("par_good_valid", valid, 1);
        check("par_good_perr", perr, 0);
        step(1'b0, 1'b0, 1'b0);
        send_bits(16'h0001);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("par_bad_valid", valid, 1);
        check("par_bad_perr", perr, 1);
        step(1'b0, 1'b0, 1'b0);
`else
        for (int i = 0; i < 66; i++) begin
            step(i < 64, 1'b0, 1'($urandom));
            if (valid) begin
                nvalid++;
                if (first < 0) first = i;
                else check("b2b_spacing", i - last, 16);
                last = i;
            end
        end
        check("b2b_count", nvalid, 4);
        check("b2b_first", first, 16);
        check("b2b_overrun", overrun, 0);
`endif

        // Randomised traffic with aborts, stalls and clears.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r     = int'($urandom_range(0, 31));
            ready = ($urandom_range(0, 3) != 0);
            clr   = ($urandom_range(0, 15) == 0);
            step(r < 28, r == 0, 1'($urandom));
        end
        clr   = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        check("drain_empty", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
